// File: rtl/seg_scan_drv_pkg.sv
// seg_pkg: shared types and constants for the seg_scan_drv display driver.
package seg_pkg;
  localparam int DIGITS = 4;
  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;
  // Active-high glyphs {g,f,e,d,c,b,a}; b and d are lowercase.
  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
endpackage

// File: rtl/seg_scan_drv_if.sv
// seg_ld_if: valid/ready load channel carrying four hex nibbles.
interface seg_ld_if;
  logic        valid;
  logic [15:0] data;
  logic        ready;
  modport master (output valid, output data, input ready);
  modport slave (input valid, input data, output ready);
endinterface

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: combinational nibble to active-high seven-segment glyph.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_glyph
);
  assign o_glyph = GLYPH[i_nib];
endmodule

// File: rtl/seg_scan_drv.sv
// seg_scan_drv: four-digit multiplexed seven-segment driver with tear-free frame commit.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module seg_scan_drv
  import seg_pkg::*;
#(
  parameter int         SEG_ACTIVE_LOW = 1,
  parameter logic [3:0] DP_MASK        = 4'b0000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   i_ph,
  input  logic         i_err_clr,
  seg_ld_if.slave      ld,
  output logic [3:0]   o_an,
  output logic [6:0]   o_seg,
  output logic         o_dp,
  output logic         o_err
);
  localparam bit POL = SEG_ACTIVE_LOW != 0;
  state_t                      r_state;
  state_t                      w_next;
  logic [15:0]                 r_act;
  logic [15:0]                 r_shd;
  logic                        r_pend;
  logic                        w_legal;
  logic                        w_boundary;
  logic                        w_accept;
  logic                        w_commit;
  logic                        w_on;
  logic                        w_blank;
  logic [$clog2(DIGITS)-1:0]   w_idx;
  logic [3:0]                  w_nib;
  logic [6:0]                  w_glyph;
  logic [3:0]                  w_an;
  logic [6:0]                  w_seg;
  logic                        w_dp;
  assign w_legal    = (i_ph != 4'b0000) && ((i_ph & (i_ph - 4'd1)) == 4'b0000);
  assign w_boundary = (r_state == RUN) && (i_ph == 4'b0001);
  assign w_accept   = ld.valid && !r_pend;
  assign w_commit   = w_boundary && r_pend;
  assign ld.ready   = !r_pend;
  assign w_idx      = {i_ph[3] | i_ph[2], i_ph[3] | i_ph[1]};
  assign w_nib      = r_act[{w_idx, 2'b00} +: 4];
`ifdef SEG_LZB_EN
  logic [15:0] w_upper;
  assign w_upper = r_act >> {w_idx, 2'b00};
  assign w_blank = (w_idx != 2'd0) && (w_upper == 16'h0000);
`else
  assign w_blank = 1'b0;
`endif
  seg_hex_decode u_dec (
    .i_nib   (w_nib),
    .o_glyph (w_glyph)
  );
  always_comb begin
    w_next = r_state;
    if (!w_legal && r_state != FAULT) w_next = FAULT;
    else if (i_ph == 4'b0001) w_next = RUN;
    w_on  = (r_state == RUN) && w_legal;
    w_an  = w_on ? i_ph : 4'b0000;
    w_seg = (w_on && !w_blank) ? w_glyph : 7'h00;
    w_dp  = w_on && !w_blank && DP_MASK[w_idx];
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_act   <= 16'h0000;
      r_shd   <= 16'h0000;
      r_pend  <= 1'b0;
      o_err   <= 1'b0;
      o_an    <= {4{POL}};
      o_seg   <= {7{POL}};
      o_dp    <= POL;
    end else begin
      r_state <= w_next;
      r_act   <= w_commit ? r_shd : r_act;
      r_shd   <= w_accept ? ld.data : r_shd;
      r_pend  <= w_commit ? 1'b0 : (w_accept ? 1'b1 : r_pend);
      // A new fault outranks a simultaneous clear.
      o_err   <= (!w_legal && r_state != FAULT) ? 1'b1 : (i_err_clr ? 1'b0 : o_err);
      o_an    <= w_an ^ {4{POL}};
      o_seg   <= w_seg ^ {7{POL}};
      o_dp    <= w_dp ^ POL;
    end
  end
endmodule

// File: doc/seg_scan_drv.md
# seg_scan_drv

Four-digit multiplexed seven-segment display driver, directly downstream of the 4-bit one-hot ring counter. Takes the ring counter's phase outputs as digit-select, accepts a new 16-bit display value over a valid/ready handshake, and commits it only at a frame boundary to prevent tearing. Drives registered anode and segment outputs. Detects non-one-hot phase input, blanks the display, and resynchronises.

## Interface
- SEG_ACTIVE_LOW, 1: 1 = anodes/segments/dp active-low; 0 = active-high.
- DP_MASK, 4'b0000: per-digit decimal-point enable; bit i lights dp while digit i is selected.
- clk  in  1  rising-edge clock; single clock domain.
- reset  in  1  synchronous, active-low reset, sampled on the clk rising edge.
- ph  in  4  phase from ring counter; ph[3:0] = {q3,q2,q1,q0}; ph[i] selects digit i.
- ld_valid  in  1  load request.
- ld_data  in  16  four hex nibbles; digit i = ld_data[4i+3:4i].
- ld_ready  out  1  block can accept a load.
- err_clr  in  1  clears err.
- an  out  4  digit enables; an[i] for digit i.
- seg  out  7  segments {g,f,e,d,c,b,a}; seg[0] = a.
- dp  out  1  decimal point.
- err  out  1  sticky phase-fault flag.

## Operation
- Registers:
  - act[15:0]: displayed value.
  - shd[15:0]: pending value.
  - pend: pending flag.
  - state: IDLE / RUN / FAULT.
- Reset (reset==0 at a clock edge):
  - State and storage: state=IDLE, act=16'h0000, shd=16'h0000, pend=0.
  - Outputs: err=0, ld_ready=1, and all display outputs off: an=4'b1111, seg=7'h7F, dp=1 for SEG_ACTIVE_LOW=1, or all zeros for SEG_ACTIVE_LOW=0.
- A reset mid-frame or mid-load discards act, shd and pend.
- ph is legal when exactly one bit is set.
- State transitions:
  - IDLE: go to RUN on ph==4'b0001; illegal ph goes to FAULT and sets err; otherwise stay. Display is off.
  - RUN: illegal ph goes to FAULT and sets err.
  - FAULT: display off. Go to RUN on ph==4'b0001; otherwise stay.
- Frame boundary: a cycle with state==RUN and ph==4'b0001.
- Handshake:
  - ld_ready = !pend.
  - Accept when ld_valid && ld_ready: shd<=ld_data, pend<=1.
  - ld_data is ignored while ld_ready==0.
  - The producer holds ld_valid until it is accepted.
- Commit: at a frame boundary with pend==1, act<=shd and pend<=0. ld_ready rises the following cycle.
- Acceptance and a frame boundary in the same cycle: the value is stored in shd and committed at the next boundary. There is no bypass into act.
- Display in RUN with legal ph:
  - Selected digit i = index of the set bit of ph.
  - an: only bit i active.
  - seg: hex glyph of act nibble i. Full 0–F set: b and d lowercase, all others uppercase.
  - dp: active iff DP_MASK[i].
- Polarity: every display output is inverted when SEG_ACTIVE_LOW=1.
- err:
  - Set on any illegal ph while in IDLE or RUN.
  - Cleared by err_clr.
  - If set and clear occur in the same cycle, set wins.

## Timing
- ph to an/seg/dp: 1 cycle latency; outputs are registered.
- Accept to visible: the commit occurs at the first frame boundary at least 1 cycle after acceptance. The new digit appears on the outputs 1 cycle after that commit edge.
- Illegal ph at edge N: err=1 and the display is off after edge N.
- Throughput: with ld_valid held high, at most one accepted load per frame (4 cycles, since the ring counter advances every clk).
- ld_ready and err are registered. No combinational path from inputs to outputs.

## Configuration
- SEG_LZB_EN defined: leading-zero blanking.
  - Digit i (i≥1) is blanked (segments and dp off, anode still active) when act nibbles i..3 are all zero.
  - Digit 0 is never blanked.
- SEG_LZB_EN undefined: every digit shows its glyph, including leading zeros.

## Structure
- Package seg_pkg holds:
  - the state enum typedef (IDLE, RUN, FAULT);
  - the 16 active-high glyph constants;
  - the DIGITS=4 constant.
- Sub-module seg_hex_decode: combinational 4-bit nibble to 7-bit active-high glyph. The top instance applies polarity.

## Test plan
- Reset with ph=4'b0001: IDLE→RUN after one edge; outputs all off during reset; act=0 shows digit 0 as "0" (SEG_ACTIVE_LOW=1: seg=7'h40, an=4'b1110).
- Load 16'h1234 mid-frame: ld_ready falls next cycle. After the next boundary, digit 0 = "4" (seg=7'h19), digit 3 = "1" (seg=7'h79). ld_ready returns to 1.
- Back-to-back loads 16'hAAAA then 16'h5555 with ld_valid held: the second is accepted only after the first commits, and each is displayed for at least one full frame.
- ph=4'b0011 in RUN: err=1, an=4'b1111 next cycle. Display recovers at the next ph=4'b0001. err stays 1 until err_clr; err_clr together with another illegal ph leaves err=1.
- SEG_LZB_EN with act=16'h0070: digits 3 and 2 blank (seg=7'h7F), digit 1 = "7", digit 0 = "0". Without the macro, all four digits are lit.
- Synchronous reset asserted with pend=1: pend and act cleared, ld_ready=1, and the pending value is never displayed.
